dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Write-back, write-allocate L1 data-cache controller between the CPU load/store port and the 2-way dcache SRAM array.
- 16 sets, 256-bit lines.
- Decodes CPU addresses, drives SRAM lookup and write ports, and runs the miss FSM against the 256-bit memory port: victim write-back, then line fill, then retry.

Parameters:
- INDEX_W, 4, set index width (16 sets)
- TAG_W, 23, address tag width
- LINE_W, 256, cache line width in bits (32 bytes, 8 words)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- cpu_req_i  in  1  CPU access request
- cpu_write_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address, word-aligned
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  CPU must hold request
- sram_enable_o  out  1  SRAM access enable
- sram_write_o  out  1  SRAM write strobe
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  {valid, dirty, tag[22:0]}
- sram_data_o  out  256  line to write
- sram_hit_i  in  1  lookup hit
- sram_tag_i  in  25  hit way tag on hit; LRU victim tag on miss
- sram_data_i  in  256  hit line on hit; LRU victim line on miss
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1 = write line, 0 = read line
- mem_addr_o  out  32  line-aligned address
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  fill line
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Interface: reset rst_i, asynchronous, active-high; clock clk_i.
- Address split: tag = addr[31:9], index = addr[8:5], word = addr[4:2]; addr[1:0] ignored.
- sram_addr_o = index at all times.
- sram_enable_o = cpu_req_i | (state != IDLE).
- States: IDLE, WRITEBACK, ALLOCATE, FILL.
- IDLE, read hit: cpu_data_o = sram_data_i word[word]; stall 0; zero added latency.
- IDLE, write hit: same cycle, sram_write_o = 1, sram_data_o = sram_data_i with word[word] replaced by cpu_data_i, sram_tag_o = {1,1,tag}; stall 0.
- IDLE, miss:
  - Latch victim tag/line, CPU tag/index/word/write/data.
  - If victim valid (bit24) and dirty (bit23), go to WRITEBACK; else go to ALLOCATE.
  - stall 1.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1.
  - mem_addr_o = {victim_tag, index, 5'b0}; mem_data_o = victim line.
  - On mem_ack_i, go to ALLOCATE.
- ALLOCATE:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {cpu_tag, index, 5'b0}.
  - On mem_ack_i, latch mem_data_i and go to FILL.
- FILL (1 cycle):
  - sram_write_o = 1.
  - Load: sram_data_o = fill line, sram_tag_o = {1,0,tag}.
  - Store: fill line merged with the store word, sram_tag_o = {1,1,tag}.
  - Go to IDLE; the retry hits next cycle and the stall drops.
- cpu_stall_o = cpu_req_i & (~sram_hit_i | state != IDLE).
- The CPU holds all request signals while stalled.
- Memory handshake:
  - mem_enable_o held high until the cycle mem_ack_i is seen, then low the next cycle.
  - mem_addr_o, mem_write_o and mem_data_o stable while mem_enable_o is high.
  - mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- Reset (including mid-miss):
  - State goes to IDLE; all latches clear.
  - Outputs: mem_enable_o = 0, mem_write_o = 0, sram_write_o = 0, mem_addr_o = 0, mem_data_o = 0, cpu_data_o = 0, sram_tag_o = 0, sram_data_o = 0.
  - cpu_stall_o follows its equation (1 if cpu_req_i and no hit).
- cpu_req_i = 0 in IDLE: no SRAM write, no counters change.

Optional Feature:
- DCACHE_PERF_CNT_EN defined adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], both reset to 0 and saturating at 0xFFFFFFFF.
- miss_cnt_o increments once per IDLE miss detection.
- hit_cnt_o increments on an IDLE hit, except the retry cycle immediately following FILL.
- Undefined: ports absent, no counter logic.

Test Plan:
- Cold load 0x0000_0040 after reset; memory returns line with word0 = 0xDEADBEEF after 10 cycles. Required:
  - mem read at 0x0000_0040.
  - FILL writes tag {1,0,0}.
  - Stall drops on retry; cpu_data_o = 0xDEADBEEF.
- Store 0x12345678 to 0x44 (hit): same cycle sram_write_o = 1, word1 replaced, tag dirty = 1, stall 0.
- Miss on dirty victim (victim tag 0x5, index 2; CPU addr 0x0000_1040). Required:
  - WRITEBACK at 0x0000_0A40 with the victim line.
  - Then ALLOCATE read at 0x0000_1040.
  - Then FILL.
- Miss on clean victim: no memory write; a single ALLOCATE read is issued.
- rst_i asserted during ALLOCATE with mem_enable_o high: mem_enable_o = 0 immediately, state IDLE; a late mem_ack_i is ignored.
- DCACHE_PERF_CNT_EN: 1 miss then 3 hits gives miss_cnt_o = 1, hit_cnt_o = 3 (retry not counted).

Source files
------------

// File: rtl/dcache_controller.sv
// dcache_controller: write-back, write-allocate L1 data-cache controller.
// Sits between the CPU load/store port, a 2-way SRAM array (16 sets, 256-bit lines) and a
// 256-bit line-wide memory port. Hits complete in the lookup cycle. A miss runs
// victim write-back (if dirty), then line fill, then the CPU retry hits.
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   cpu_req_i/write_i/addr_i   CPU request, store flag, word-aligned byte address
//   cpu_data_i/o, cpu_stall_o  store data, load data, hold-request indication
//   sram_enable_o/write_o      SRAM lookup enable, write strobe
//   sram_addr_o/tag_o/data_o   set index, {valid, dirty, tag}, line to write
//   sram_hit_i/tag_i/data_i    lookup result (hit way, or LRU victim on miss)
//   mem_enable_o/write_o       memory request, 1 = write line / 0 = read line
//   mem_addr_o/data_o/data_i   line-aligned address, write-back line, fill line
//   mem_ack_i                  one-cycle completion pulse
//
// Optional build macro: DCACHE_PERF_CNT_EN adds saturating hit_cnt_o / miss_cnt_o.

module dcache_controller #(
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned TAG_W   = 23,
    parameter int unsigned LINE_W  = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cpu_req_i,
    input  logic               cpu_write_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic [31:0]        cpu_data_i,
    output logic [31:0]        cpu_data_o,
    output logic               cpu_stall_o,
    output logic               sram_enable_o,
    output logic               sram_write_o,
    output logic [INDEX_W-1:0] sram_addr_o,
    output logic [TAG_W+1:0]   sram_tag_o,
    output logic [LINE_W-1:0]  sram_data_o,
    input  logic               sram_hit_i,
    input  logic [TAG_W+1:0]   sram_tag_i,
    input  logic [LINE_W-1:0]  sram_data_i,
    output logic               mem_enable_o,
    output logic               mem_write_o,
    output logic [31:0]        mem_addr_o,
    output logic [LINE_W-1:0]  mem_data_o,
    input  logic [LINE_W-1:0]  mem_data_i,
`ifdef DCACHE_PERF_CNT_EN
    output logic [31:0]        hit_cnt_o,
    output logic [31:0]        miss_cnt_o,
`endif
    input  logic               mem_ack_i
);

    typedef enum logic [1:0] {StIdle, StWriteback, StAllocate, StFill} state_e;

    state_e              state_q, state_d;
    logic [TAG_W-1:0]    vtag_q, ctag_q;
    logic [INDEX_W-1:0]  cidx_q;
    logic [2:0]          cword_q;
    logic                cwrite_q;
    logic [31:0]         cdata_q;
    logic [LINE_W-1:0]   vline_q, fill_q;

    logic [TAG_W-1:0]    cpu_tag;
    logic [INDEX_W-1:0]  cpu_idx;
    logic [2:0]          cpu_word;
    logic                miss_det;
    logic [LINE_W-1:0]   line;
    logic                unused_addr;

    assign cpu_tag     = cpu_addr_i[31 -: TAG_W];
    assign cpu_idx     = cpu_addr_i[5 +: INDEX_W];
    assign cpu_word    = cpu_addr_i[4:2];
    assign unused_addr = ^cpu_addr_i[1:0];

    assign sram_addr_o   = cpu_idx;
    assign sram_enable_o = cpu_req_i | (state_q != StIdle);
    assign cpu_stall_o   = cpu_req_i & (~sram_hit_i | (state_q != StIdle));
    assign miss_det      = (state_q == StIdle) & cpu_req_i & ~sram_hit_i;

    always_comb begin
        state_d      = state_q;
        cpu_data_o   = '0;
        sram_write_o = 1'b0;
        sram_tag_o   = '0;
        sram_data_o  = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        line         = '0;
        // Outputs are forced quiet while reset is held, even though IDLE hits would drive them.
        if (!rst_i) begin
            unique case (state_q)
                StIdle: begin
                    if (cpu_req_i && sram_hit_i) begin
                        if (cpu_write_i) begin
                            line                      = sram_data_i;
                            line[{cpu_word, 5'b0} +: 32] = cpu_data_i;
                            sram_write_o              = 1'b1;
                            sram_data_o               = line;
                            sram_tag_o                = {2'b11, cpu_tag};
                        end else begin
                            cpu_data_o = sram_data_i[{cpu_word, 5'b0} +: 32];
                        end
                    end else if (cpu_req_i) begin
                        // Only a valid and dirty victim needs to go back to memory.
                        state_d = (sram_tag_i[TAG_W+1] && sram_tag_i[TAG_W]) ? StWriteback
                                                                             : StAllocate;
                    end
                end
                StWriteback: begin
                    mem_enable_o = 1'b1;
                    mem_write_o  = 1'b1;
                    mem_addr_o   = {vtag_q, cidx_q, 5'b0};
                    mem_data_o   = vline_q;
                    if (mem_ack_i) state_d = StAllocate;
                end
                StAllocate: begin
                    mem_enable_o = 1'b1;
                    mem_addr_o   = {ctag_q, cidx_q, 5'b0};
                    if (mem_ack_i) state_d = StFill;
                end
                StFill: begin
                    line = fill_q;
                    if (cwrite_q) line[{cword_q, 5'b0} +: 32] = cdata_q;
                    sram_write_o = 1'b1;
                    sram_data_o  = line;
                    sram_tag_o   = {1'b1, cwrite_q, ctag_q};
                    state_d      = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            vtag_q   <= '0;
            vline_q  <= '0;
            ctag_q   <= '0;
            cidx_q   <= '0;
            cword_q  <= '0;
            cwrite_q <= 1'b0;
            cdata_q  <= '0;
            fill_q   <= '0;
        end else begin
            state_q <= state_d;
            if (miss_det) begin
                vtag_q   <= sram_tag_i[TAG_W-1:0];
                vline_q  <= sram_data_i;
                ctag_q   <= cpu_tag;
                cidx_q   <= cpu_idx;
                cword_q  <= cpu_word;
                cwrite_q <= cpu_write_i;
                cdata_q  <= cpu_data_i;
            end
            if (state_q == StAllocate && mem_ack_i) fill_q <= mem_data_i;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic        retry_q;
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        hit_det;

    // The retry right after FILL is the completion of a counted miss, not a new hit.
    assign hit_det = (state_q == StIdle) & cpu_req_i & sram_hit_i & ~retry_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retry_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            retry_q <= (state_q == StFill);
            if (hit_det && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (miss_det && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed testbench for dcache_controller. The bench plays the SRAM array and memory
// by driving lookup results and ack pulses directly; expected values are hand-derived.

module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_write_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o, sram_enable_o, sram_write_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o, sram_tag_i;
    logic [255:0] sram_data_o, sram_data_i;
    logic         sram_hit_i;
    logic         mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] line_a, line_b, line_c, line_d, exp_line;

    always #5 clk_i = ~clk_i;

    dcache_controller dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cpu_req_i     (cpu_req_i),
        .cpu_write_i   (cpu_write_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_data_i    (cpu_data_i),
        .cpu_data_o    (cpu_data_o),
        .cpu_stall_o   (cpu_stall_o),
        .sram_enable_o (sram_enable_o),
        .sram_write_o  (sram_write_o),
        .sram_addr_o   (sram_addr_o),
        .sram_tag_o    (sram_tag_o),
        .sram_data_o   (sram_data_o),
        .sram_hit_i    (sram_hit_i),
        .sram_tag_i    (sram_tag_i),
        .sram_data_i   (sram_data_i),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i),
`ifdef DCACHE_PERF_CNT_EN
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o),
`endif
        .mem_ack_i     (mem_ack_i)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled off-edge.
    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    initial begin
        line_a = mk_line(32'hA000_0000);
        line_a[31:0] = 32'hDEAD_BEEF;
        line_b = mk_line(32'hB000_0000);
        line_c = mk_line(32'hC000_0000);
        line_d = mk_line(32'hD000_0000);

        rst_i = 1'b1; cpu_req_i = 1'b0; cpu_write_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
        sram_hit_i = 1'b0; sram_tag_i = '0; sram_data_i = '0; mem_data_i = '0; mem_ack_i = 1'b0;
        #3;
        check_eq("rst_mem_en", 256'(mem_enable_o), 256'd0);
        check_eq("rst_sram_wr", 256'(sram_write_o), 256'd0);
        check_eq("rst_stall_idle", 256'(cpu_stall_o), 256'd0);
        cpu_req_i = 1'b1;
        #1;
        check_eq("rst_stall_req", 256'(cpu_stall_o), 256'd1);
        check_eq("rst_mem_addr", 256'(mem_addr_o), 256'd0);
        cpu_req_i = 1'b0;
        step(); step();
        rst_i = 1'b0;
        step();

        // Cold load miss at 0x40, clean (invalid) victim.
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h40;
        #1;
        check_eq("cold_stall", 256'(cpu_stall_o), 256'd1);
        check_eq("cold_sram_addr", 256'(sram_addr_o), 256'd2);
        check_eq("cold_sram_en", 256'(sram_enable_o), 256'd1);
        step();
        check_eq("cold_mem_en", 256'(mem_enable_o), 256'd1);
        check_eq("cold_mem_wr", 256'(mem_write_o), 256'd0);
        check_eq("cold_mem_addr", 256'(mem_addr_o), 256'h40);
        repeat (9) step();
        check_eq("cold_mem_hold", 256'(mem_enable_o), 256'd1);
        mem_data_i = line_a; mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        check_eq("cold_fill_wr", 256'(sram_write_o), 256'd1);
        check_eq("cold_fill_tag", 256'(sram_tag_o), 256'h100_0000);
        check_eq("cold_fill_data", sram_data_o, line_a);
        check_eq("cold_fill_mem_en", 256'(mem_enable_o), 256'd0);
        sram_hit_i = 1'b1; sram_tag_i = 25'h100_0000; sram_data_i = line_a;
        step();
        check_eq("cold_retry_stall", 256'(cpu_stall_o), 256'd0);
        check_eq("cold_retry_data", 256'(cpu_data_o), 256'hDEAD_BEEF);

        // Store hit to 0x44 (word 1).
        cpu_write_i = 1'b1; cpu_addr_i = 32'h44; cpu_data_i = 32'h1234_5678;
        exp_line = line_a;
        exp_line[63:32] = 32'h1234_5678;
        #1;
        check_eq("st_hit_wr", 256'(sram_write_o), 256'd1);
        check_eq("st_hit_data", sram_data_o, exp_line);
        check_eq("st_hit_tag", 256'(sram_tag_o), 256'h180_0000);
        check_eq("st_hit_stall", 256'(cpu_stall_o), 256'd0);
        step();

        // Load miss at 0x1040 with dirty victim tag 0x5 in set 2.
        cpu_write_i = 1'b0; cpu_addr_i = 32'h1040;
        sram_hit_i = 1'b0; sram_tag_i = 25'h180_0005; sram_data_i = line_b;
        #1;
        check_eq("dirty_stall", 256'(cpu_stall_o), 256'd1);
        step();
        sram_tag_i = '0; sram_data_i = '0;
        check_eq("wb_mem_en", 256'(mem_enable_o), 256'd1);
        check_eq("wb_mem_wr", 256'(mem_write_o), 256'd1);
        check_eq("wb_mem_addr", 256'(mem_addr_o), 256'hA40);
        check_eq("wb_mem_data", mem_data_o, line_b);
        step(); step();
        check_eq("wb_hold_data", mem_data_o, line_b);
        mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        check_eq("alloc_mem_en", 256'(mem_enable_o), 256'd1);
        check_eq("alloc_mem_wr", 256'(mem_write_o), 256'd0);
        check_eq("alloc_mem_addr", 256'(mem_addr_o), 256'h1040);
        mem_data_i = line_c; mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        check_eq("dirty_fill_wr", 256'(sram_write_o), 256'd1);
        check_eq("dirty_fill_tag", 256'(sram_tag_o), 256'h100_0008);
        check_eq("dirty_fill_data", sram_data_o, line_c);
        sram_hit_i = 1'b1; sram_tag_i = 25'h100_0008; sram_data_i = line_c;
        step();
        check_eq("dirty_retry_stall", 256'(cpu_stall_o), 256'd0);
        check_eq("dirty_retry_data", 256'(cpu_data_o), 256'hC000_0000);

        // Store miss at 0x2084 (set 4, word 1) with clean victim: straight to ALLOCATE.
        cpu_write_i = 1'b1; cpu_addr_i = 32'h2084; cpu_data_i = 32'hCAFE_F00D;
        sram_hit_i = 1'b0; sram_tag_i = 25'h100_0007; sram_data_i = line_b;
        step();
        check_eq("clean_mem_wr", 256'(mem_write_o), 256'd0);
        check_eq("clean_mem_addr", 256'(mem_addr_o), 256'h2080);
        mem_data_i = line_d; mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        exp_line = line_d;
        exp_line[63:32] = 32'hCAFE_F00D;
        check_eq("st_fill_tag", 256'(sram_tag_o), 256'h180_0010);
        check_eq("st_fill_data", sram_data_o, exp_line);
        sram_hit_i = 1'b1; sram_tag_i = 25'h180_0010; sram_data_i = exp_line;
        step();
        check_eq("st_retry_stall", 256'(cpu_stall_o), 256'd0);

        // Reset asserted mid-ALLOCATE; a late ack must be ignored.
        cpu_write_i = 1'b0; cpu_addr_i = 32'h3000; sram_hit_i = 1'b0; sram_tag_i = '0;
        step();
        check_eq("rstmid_mem_en_before", 256'(mem_enable_o), 256'd1);
        #1 rst_i = 1'b1;
        #1;
        check_eq("rstmid_mem_en", 256'(mem_enable_o), 256'd0);
        check_eq("rstmid_mem_addr", 256'(mem_addr_o), 256'd0);
        step();
        rst_i = 1'b0; cpu_req_i = 1'b0; mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        check_eq("late_ack_mem_en", 256'(mem_enable_o), 256'd0);
        check_eq("late_ack_sram_en", 256'(sram_enable_o), 256'd0);
        check_eq("late_ack_sram_wr", 256'(sram_write_o), 256'd0);
        step();
        check_eq("late_ack_mem_en2", 256'(mem_enable_o), 256'd0);

`ifdef DCACHE_PERF_CNT_EN
        // One miss, the uncounted retry, then three counted hits.
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check_eq("perf_rst_hit", 256'(hit_cnt_o), 256'd0);
        cpu_req_i = 1'b1; cpu_addr_i = 32'h40; sram_hit_i = 1'b0; sram_tag_i = '0;
        step();
        mem_data_i = line_a; mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0; sram_hit_i = 1'b1; sram_data_i = line_a;
        step();
        repeat (4) step();
        cpu_req_i = 1'b0;
        check_eq("perf_miss_cnt", 256'(miss_cnt_o), 256'd1);
        check_eq("perf_hit_cnt", 256'(hit_cnt_o), 256'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
